// File: rtl/mult_pkg.sv
// mult_pkg: shared types and helpers for the iterative multiplier.
package mult_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam int STEP_1 = 1;
    localparam int STEP_2 = 2;
    localparam int STEP_4 = 4;
    localparam int STEP_8 = 8;
    function automatic int count_width(input int width, input int step);
        return (width / step > 1) ? $clog2(width / step) : 1;
    endfunction
    function automatic bit step_ok(input int step);
        return step == STEP_1 || step == STEP_2 || step == STEP_4 || step == STEP_8;
    endfunction
endpackage

// File: rtl/mult_iter_pp.sv
// mult_iter_pp: multiplicand times a STEP-bit digit as a sum of shifted copies.
module mult_iter_pp #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [STEP-1:0]    digit,
    output logic [2*WIDTH-1:0] pp
);
    always_comb begin
        pp = '0;
        for (int i = 0; i < STEP; i++)
            pp = digit[i] ? pp + (mcand << i) : pp;
    end
endmodule

// File: rtl/mult_iter.sv
// mult_iter: iterative signed/unsigned multiplier retiring STEP bits per cycle.
// Define MULT_ITER_ABORT_EN to add the mult_abort flush input.
module mult_iter
    import mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mult_begin,
    input  logic               mult_signed,
    input  logic [WIDTH-1:0]   mult_op1,
    input  logic [WIDTH-1:0]   mult_op2,
`ifdef MULT_ITER_ABORT_EN
    input  logic               mult_abort,
`endif
    output logic [2*WIDTH-1:0] product,
    output logic               mult_end,
    output logic               mult_busy
);
    localparam int N  = WIDTH / STEP;
    localparam int CW = count_width(WIDTH, STEP);
    state_t             state;
    logic [2*WIDTH-1:0] mcand, acc, pp, acc_next;
    logic [WIDTH-1:0]   mplier, op1_abs, op2_abs;
    logic [CW-1:0]      count;
    logic               sign, abort;
    assign op1_abs  = (mult_signed && mult_op1[WIDTH-1]) ? -mult_op1 : mult_op1;
    assign op2_abs  = (mult_signed && mult_op2[WIDTH-1]) ? -mult_op2 : mult_op2;
    assign acc_next = acc + pp;
`ifdef MULT_ITER_ABORT_EN
    assign abort = mult_abort;
`else
    assign abort = 1'b0;
`endif
    mult_iter_pp #(.WIDTH(WIDTH), .STEP(STEP)) u_pp (
        .mcand(mcand),
        .digit(mplier[STEP-1:0]),
        .pp   (pp)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            product   <= '0;
            mult_end  <= 1'b0;
            mult_busy <= 1'b0;
            count     <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            sign      <= 1'b0;
        end else begin
            mult_end <= 1'b0;
            case (state)
                CALC: begin
                    if (abort) begin
                        state     <= IDLE;
                        mult_busy <= 1'b0;
                    end else begin
                        acc    <= acc_next;
                        mcand  <= mcand << STEP;
                        mplier <= mplier >> STEP;
                        if (count == '0) begin
                            state     <= DONE;
                            mult_busy <= 1'b0;
                            mult_end  <= 1'b1;
                            product   <= sign ? -acc_next : acc_next;
                        end else begin
                            count <= count - 1'b1;
                        end
                    end
                end
                // IDLE and DONE both accept a new start, giving back-to-back issue
                default: begin
                    if (mult_begin) begin
                        state     <= CALC;
                        mult_busy <= 1'b1;
                        mcand     <= {{WIDTH{1'b0}}, op1_abs};
                        mplier    <= op2_abs;
                        sign      <= mult_signed & (mult_op1[WIDTH-1] ^ mult_op2[WIDTH-1]);
                        acc       <= '0;
                        count     <= CW'(N - 1);
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_iter.sv
// tb_mult_iter: randomized scoreboard bench for mult_iter against an arithmetic reference.
module tb_mult_iter;
    localparam int W = 32;
    localparam int STEP = 4;
    localparam int N = W / STEP;

    typedef struct {
        logic [2*W-1:0] prod;
        int             start;
        int             due;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           mult_begin = 1'b0;
    logic           mult_signed = 1'b0;
    logic [W-1:0]   mult_op1 = '0;
    logic [W-1:0]   mult_op2 = '0;
`ifdef MULT_ITER_ABORT_EN
    logic           mult_abort = 1'b0;
`endif
    logic [2*W-1:0] product;
    logic           mult_end, mult_busy;

    int             checks = 0;
    int             failures = 0;
    int             cyc = 0;
    exp_t           q[$];
    logic [2*W-1:0] last_prod = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult_iter #(.WIDTH(W), .STEP(STEP)) dut (
        .clk        (clk),
        .reset      (reset),
        .mult_begin (mult_begin),
        .mult_signed(mult_signed),
        .mult_op1   (mult_op1),
        .mult_op2   (mult_op2),
`ifdef MULT_ITER_ABORT_EN
        .mult_abort (mult_abort),
`endif
        .product    (product),
        .mult_end   (mult_end),
        .mult_busy  (mult_busy)
    );

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] ea, eb;
        ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return ea * eb;
    endfunction

    function automatic logic [W-1:0] pick();
        int k;
        k = $urandom_range(0, 5);
        return k == 0 ? '0 : k == 1 ? '1 : k == 2 ? {1'b1, {(W-1){1'b0}}} : k == 3 ? W'(1) : W'($urandom);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] e);
        mult_begin  = 1'b1;
        mult_signed = s;
        mult_op1    = a;
        mult_op2    = b;
        q.push_back('{e, cyc + 1, cyc + 1 + N});
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 2 * N + 8 && q.size() > 0; i++) tick();
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] e, input bit pulse);
        tick();
        start_op(s, a, b, e);
        tick();
        mult_begin  = 1'b0;
        mult_op1    = $urandom;
        mult_op2    = $urandom;
        mult_signed = 1'($urandom);
        if (pulse) begin
            repeat ($urandom_range(0, N - 2)) tick();
            mult_begin = 1'b1;
            tick();
            mult_begin = 1'b0;
        end
        wait_drain();
    endtask

    // Monitor: scoreboard pop on every completion, busy and hold checks each cycle
    initial begin : mon
        logic busy_exp;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                last_prod = '0;
            end else begin
                busy_exp = q.size() > 0 && cyc >= q[0].start && cyc < q[0].due;
                check("busy", {{(2*W-1){1'b0}}, mult_busy}, {{(2*W-1){1'b0}}, busy_exp});
                if (mult_end && q.size() == 0) begin
                    check("spurious_end", {{(2*W-1){1'b0}}, mult_end}, '0);
                end else if (mult_end) begin
                    e = q.pop_front();
                    check("product", product, e.prod);
                    check("latency", 64'(cyc), 64'(e.due));
                    last_prod = e.prod;
                end else begin
                    check("product_hold", product, last_prod);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic           s;
        logic [W-1:0]   a, b;
        int             d;
        #2;
        check("rst_product", product, '0);
        check("rst_end", {{(2*W-1){1'b0}}, mult_end}, '0);
        check("rst_busy", {{(2*W-1){1'b0}}, mult_busy}, '0);
        @(posedge clk);
        #1 reset = 1'b0;

        run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b0);
        run_op(1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000, 1'b0);
        run_op(1'b1, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFFFFFFFFEB, 1'b0);
        run_op(1'b1, 32'hFFFFFFFF, 32'h12345678, 64'hFFFFFFFFEDCBA988, 1'b0);
        run_op(1'b1, 32'h00000000, 32'h80000000, 64'h0, 1'b1);
        run_op(1'b0, 32'h00000006, 32'h00000007, 64'd42, 1'b1);

        // begin held high across two back-to-back operations
        tick();
        start_op(1'b0, 32'd6, 32'd7, 64'd42);
        d = cyc + 1 + N;
        while (cyc < d) tick();
        start_op(1'b0, 32'd0, 32'd5, 64'd0);
        d = cyc + 1 + N;
        while (cyc < d) tick();
        mult_begin = 1'b0;
        wait_drain();

        repeat (30) begin
            s = 1'($urandom);
            a = pick();
            b = pick();
            run_op(s, a, b, ref_mul(s, a, b), bit'($urandom_range(0, 1)));
        end

        // asynchronous reset in the middle of a calculation
        run_op(1'b0, 32'd6, 32'd7, 64'd42, 1'b0);
        tick();
        start_op(1'b0, 32'h1234, 32'h5678, 64'h0);
        tick();
        mult_begin = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        q.delete();
        check("midrst_product", product, '0);
        check("midrst_end", {{(2*W-1){1'b0}}, mult_end}, '0);
        check("midrst_busy", {{(2*W-1){1'b0}}, mult_busy}, '0);
        @(posedge clk);
        #1 reset = 1'b0;
        run_op(1'b1, 32'hFFFFFFF0, 32'd3, 64'hFFFFFFFFFFFFFFD0, 1'b0);

`ifdef MULT_ITER_ABORT_EN
        run_op(1'b0, 32'd6, 32'd7, 64'h2A, 1'b0);
        tick();
        start_op(1'b0, 32'd3, 32'd5, 64'd15);
        tick();
        mult_begin = 1'b0;
        repeat (4) tick();
        mult_abort = 1'b1;
        tick();
        mult_abort = 1'b0;
        q.delete();
        repeat (N) tick();
        check("abort_hold", product, 64'h2A);
        tick();
        start_op(1'b0, 32'd3, 32'd5, 64'd15);
        d = cyc + N;
        tick();
        mult_begin = 1'b0;
        while (cyc < d) tick();
        mult_abort = 1'b1;
        tick();
        mult_abort = 1'b0;
        q.delete();
        repeat (3) tick();
        check("abort_last_hold", product, 64'h2A);
        mult_abort = 1'b1;
        tick();
        mult_abort = 1'b0;
        run_op(1'b1, 32'hFFFFFFFE, 32'hFFFFFFFD, 64'd6, 1'b0);
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
